find_extreme_scanner: RTL and testbench
=======================================

// Module: find_extreme_scanner
// PURPOSE
//  Parametrised RAM-sweep peak finder; successor to the fixed 128x8 max reader.
//  On a rising edge of readyb it reads DEPTH words from a sync RAM port (read latency RD_LAT),
//  tracks the max (or min, by MODE) value and its first address, then pulses finishb.
//  Sits between the capture RAM B-port and the measurement/report logic.
// PARAMETERS
//  DATA_W  8    sample width
//  ADDR_W  7    RAM address width
//  DEPTH   128  words scanned per sweep, 2..2^ADDR_W
//  RD_LAT  2    cycles from addr to valid dout, 1..4
//  MODE    0    0 = find max, 1 = find min
//  SIGNED  0    1 = compare dout as two's complement
// PORTS
//  clk_in         in   1       sole clock
//  rst_n          in   1       async active-low reset
//  readyb         in   1       RAM-ready level; rising edge starts a sweep
//  abort          in   1       sync; cancels sweep in progress
//  dout           in   DATA_W  RAM read data
//  addr           out  ADDR_W  RAM read address
//  busy           out  1       high from sweep start until finishb/abort
//  finishb        out  1       1-cycle pulse, results valid
//  ext_data       out  DATA_W  extreme value found
//  ext_addr       out  ADDR_W  address of first occurrence of extreme
//  ext_valid      out  1       ext_* hold a completed sweep's result
//  no_ext_flag    out  1       all DEPTH samples were equal (valid with ext_valid)
// BEHAVIOUR
//  Reset: state IDLE; addr=0, busy=0, finishb=0, ext_data=0, ext_addr=0, ext_valid=0,
//   no_ext_flag=0; readyb edge register resets to 1, so readyb already high at reset
//   release does NOT start a sweep. Reset mid-sweep discards all partial results.
//  Edge detect: start = readyb & ~readyb_q, evaluated only in IDLE; edges while
//   busy are ignored (not queued).
//  FSM: IDLE -start-> READ -(addr==DEPTH-1 issued)-> DRAIN -(RD_LAT cycles)-> DONE -> IDLE.
//   Start-cycle T: at T+1 state=READ, addr=0, busy=1, ext_valid=0, no_ext_flag=0.
//   READ: addr increments once per cycle, 0..DEPTH-1; after DEPTH-1 addr returns to 0.
//   DRAIN: addr held 0; waits for last RD_LAT read returns.
//   DONE: finishb=1 for exactly one cycle at T+DEPTH+RD_LAT+1; same cycle ext_valid=1, busy=0.
//  Pipeline: an RD_LAT-deep shift of {valid, addr} aligns each address with its dout;
//   dout is sampled only when the delayed valid is high.
//  Compare: first sample loads the running extreme unconditionally. Thereafter replace
//   only on strictly greater (MODE=0) / strictly less (MODE=1), so ties keep lowest address.
//   SIGNED selects $signed compare; no arithmetic, no width growth.
//  no_ext_flag: set at DONE if no sample differed from sample 0.
//  ext_* are registered; they hold until the next sweep start (cleared then) or reset.
//  abort: in READ/DRAIN -> IDLE next cycle, addr=0, busy=0, no finishb, ext_valid stays 0;
//   in IDLE/DONE ignored. abort and start in same cycle: abort wins (no sweep).
// TESTING
//  RAM[i]=i, DEPTH=128, RD_LAT=2, pulse readyb -> finishb at T+131, ext_data=127, ext_addr=127, no_ext_flag=0.
//  RAM all 0x55 -> ext_data=0x55, ext_addr=0, no_ext_flag=1.
//  RAM 0x80 at addr 10 and 90, else 0x10 -> ext_addr=10 (first tie wins).
//  MODE=1, SIGNED=1, RAM[33]=0xF0, others 0x05 -> ext_data=0xF0, ext_addr=33; SIGNED=0 -> ext_data=0x05, ext_addr=0.
//  Second readyb edge at T+40 -> ignored, single finishb at T+131; abort at T+50 -> busy=0 at T+51, no finishb, ext_valid=0.
//  readyb high through reset release -> no sweep; rst_n low at T+60 -> all outputs reset values immediately.

Source files
------------

// File: rtl/find_extreme_scanner.sv
// Sweeps DEPTH words of a synchronous RAM port and reports the max (MODE=0) or min (MODE=1)
// value together with the lowest address holding it; finishb pulses once the result is final.
module find_extreme_scanner #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 128,
    parameter int RD_LAT = 2,
    parameter int MODE   = 0,
    parameter int SIGNED = 0
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              readyb,
    input  logic              abort,
    input  logic [DATA_W-1:0] dout,
    output logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              finishb,
    output logic [DATA_W-1:0] ext_data,
    output logic [ADDR_W-1:0] ext_addr,
    output logic              ext_valid,
    output logic              no_ext_flag
);

    localparam int CNT_W = 3;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  LAST_DRAIN = CNT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                readyb_q;
    logic                start;
    logic                start_sweep;
    logic                enter_done;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    drain_cnt_q, drain_cnt_d;
    logic                busy_q, busy_d;
    logic                finishb_q, finishb_d;

    logic [RD_LAT-1:0]   pipe_vld_q;
    logic [ADDR_W-1:0]   pipe_addr_q [RD_LAT];
    logic                smp_vld;
    logic [ADDR_W-1:0]   smp_addr;

    logic [DATA_W-1:0]   run_data_q, run_data_d;
    logic [ADDR_W-1:0]   run_addr_q, run_addr_d;
    logic [DATA_W-1:0]   first_data_q, first_data_d;
    logic                have_first_q, have_first_d;
    logic                diff_q, diff_d;
    logic                better;

    logic [DATA_W-1:0]   ext_data_q, ext_data_d;
    logic [ADDR_W-1:0]   ext_addr_q, ext_addr_d;
    logic                ext_valid_q, ext_valid_d;
    logic                no_ext_q, no_ext_d;

    // readyb_q resets high so a level already present at reset release is not an edge
    assign start       = readyb & ~readyb_q;
    assign start_sweep = (state_q == S_IDLE) && start && !abort;
    assign enter_done  = (state_q == S_DRAIN) && (state_d == S_DONE);
    assign smp_vld     = pipe_vld_q[RD_LAT-1];
    assign smp_addr    = pipe_addr_q[RD_LAT-1];

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start && !abort) state_d = S_READ;
            S_READ: begin
                if (abort)                   state_d = S_IDLE;
                else if (addr_q == LAST_ADDR) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (abort)                          state_d = S_IDLE;
                else if (drain_cnt_q == LAST_DRAIN) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d      = '0;
        drain_cnt_d = '0;
        busy_d      = 1'b0;
        finishb_d   = 1'b0;
        case (state_d)
            S_READ: begin
                busy_d = 1'b1;
                addr_d = (state_q == S_READ) ? addr_q + 1'b1 : '0;
            end
            S_DRAIN: begin
                busy_d      = 1'b1;
                drain_cnt_d = (state_q == S_DRAIN) ? drain_cnt_q + 1'b1 : '0;
            end
            S_DONE:  finishb_d = 1'b1;
            default: ;
        endcase
    end

    // Each issued address travels alongside its read so it meets the matching dout
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_addr_q[i] <= '0;
        end else begin
            pipe_vld_q[0]  <= (state_q == S_READ) & ~abort;
            pipe_addr_q[0] <= addr_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1] & ~abort;
                pipe_addr_q[i] <= pipe_addr_q[i-1];
            end
        end
    end

    always_comb begin
        better = 1'b0;
        if (SIGNED != 0) begin
            better = (MODE != 0) ? ($signed(dout) < $signed(run_data_q))
                                 : ($signed(dout) > $signed(run_data_q));
        end else begin
            better = (MODE != 0) ? (dout < run_data_q) : (dout > run_data_q);
        end
    end

    always_comb begin
        run_data_d   = run_data_q;
        run_addr_d   = run_addr_q;
        first_data_d = first_data_q;
        have_first_d = have_first_q;
        diff_d       = diff_q;
        if (start_sweep) begin
            have_first_d = 1'b0;
            diff_d       = 1'b0;
        end else if (smp_vld) begin
            if (!have_first_q) begin
                run_data_d   = dout;
                run_addr_d   = smp_addr;
                first_data_d = dout;
                have_first_d = 1'b1;
            end else begin
                // Strict compare only: a tie keeps the earlier address
                if (better) begin
                    run_data_d = dout;
                    run_addr_d = smp_addr;
                end
                if (dout != first_data_q) diff_d = 1'b1;
            end
        end
    end

    always_comb begin
        ext_data_d  = ext_data_q;
        ext_addr_d  = ext_addr_q;
        ext_valid_d = ext_valid_q;
        no_ext_d    = no_ext_q;
        if (start_sweep) begin
            ext_data_d  = '0;
            ext_addr_d  = '0;
            ext_valid_d = 1'b0;
            no_ext_d    = 1'b0;
        end else if (enter_done) begin
            ext_data_d  = run_data_d;
            ext_addr_d  = run_addr_d;
            ext_valid_d = 1'b1;
            no_ext_d    = ~diff_d;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            readyb_q     <= 1'b1;
            addr_q       <= '0;
            drain_cnt_q  <= '0;
            busy_q       <= 1'b0;
            finishb_q    <= 1'b0;
            run_data_q   <= '0;
            run_addr_q   <= '0;
            first_data_q <= '0;
            have_first_q <= 1'b0;
            diff_q       <= 1'b0;
            ext_data_q   <= '0;
            ext_addr_q   <= '0;
            ext_valid_q  <= 1'b0;
            no_ext_q     <= 1'b0;
        end else begin
            readyb_q     <= readyb;
            addr_q       <= addr_d;
            drain_cnt_q  <= drain_cnt_d;
            busy_q       <= busy_d;
            finishb_q    <= finishb_d;
            run_data_q   <= run_data_d;
            run_addr_q   <= run_addr_d;
            first_data_q <= first_data_d;
            have_first_q <= have_first_d;
            diff_q       <= diff_d;
            ext_data_q   <= ext_data_d;
            ext_addr_q   <= ext_addr_d;
            ext_valid_q  <= ext_valid_d;
            no_ext_q     <= no_ext_d;
        end
    end

    assign addr        = addr_q;
    assign busy        = busy_q;
    assign finishb     = finishb_q;
    assign ext_data    = ext_data_q;
    assign ext_addr    = ext_addr_q;
    assign ext_valid   = ext_valid_q;
    assign no_ext_flag = no_ext_q;

endmodule

// File: tb/tb_find_extreme_scanner.sv
// Bench for find_extreme_scanner: three instances (max unsigned, min signed, min unsigned)
// sweep a shared RAM image and are compared every cycle against a timeline/result model.
module tb_find_extreme_scanner;

    localparam int DW = 8;
    localparam int AW = 7;
    localparam int DEPTH = 128;
    localparam int RDL = 2;
    localparam int ND = 3;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic rst_n, readyb, abort;
    logic [DW-1:0] ram [DEPTH];

    logic [AW-1:0] addr_w     [ND];
    logic [DW-1:0] dout_w     [ND];
    logic [DW-1:0] rd1        [ND];
    logic [DW-1:0] ext_data_w [ND];
    logic [AW-1:0] ext_addr_w [ND];
    logic [ND-1:0] busy, finishb, ext_valid, flag;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    find_extreme_scanner #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(RDL), .MODE(0), .SIGNED(0)) u_max (
        .clk_in(clk_in), .rst_n(rst_n), .readyb(readyb), .abort(abort), .dout(dout_w[0]),
        .addr(addr_w[0]), .busy(busy[0]), .finishb(finishb[0]), .ext_data(ext_data_w[0]),
        .ext_addr(ext_addr_w[0]), .ext_valid(ext_valid[0]), .no_ext_flag(flag[0]));

    find_extreme_scanner #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(RDL), .MODE(1), .SIGNED(1)) u_min_s (
        .clk_in(clk_in), .rst_n(rst_n), .readyb(readyb), .abort(abort), .dout(dout_w[1]),
        .addr(addr_w[1]), .busy(busy[1]), .finishb(finishb[1]), .ext_data(ext_data_w[1]),
        .ext_addr(ext_addr_w[1]), .ext_valid(ext_valid[1]), .no_ext_flag(flag[1]));

    find_extreme_scanner #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(RDL), .MODE(1), .SIGNED(0)) u_min_u (
        .clk_in(clk_in), .rst_n(rst_n), .readyb(readyb), .abort(abort), .dout(dout_w[2]),
        .addr(addr_w[2]), .busy(busy[2]), .finishb(finishb[2]), .ext_data(ext_data_w[2]),
        .ext_addr(ext_addr_w[2]), .ext_valid(ext_valid[2]), .no_ext_flag(flag[2]));

    // Two-stage registered read port per instance
    always @(posedge clk_in) begin
        for (int d = 0; d < ND; d++) begin
            rd1[d]    <= ram[addr_w[d]];
            dout_w[d] <= rd1[d];
        end
    end

    // ---------------- model ----------------
    bit            m_active = 0;
    int            m_p = 0;
    bit            m_rdy_prev = 1;
    bit            m_start;
    bit            m_ext_valid = 0;
    bit            m_flag = 0;
    bit            pend_flag;
    logic [DW-1:0] m_ext_data [ND];
    logic [AW-1:0] m_ext_addr [ND];
    logic [DW-1:0] pend_data  [ND];
    logic [AW-1:0] pend_addr  [ND];

    function automatic bit beats(int d, logic [DW-1:0] a, logic [DW-1:0] b);
        case (d)
            0:       return a > b;
            1:       return $signed(a) < $signed(b);
            default: return a < b;
        endcase
    endfunction

    function automatic void compute_pending();
        logic [DW-1:0] best;
        int fi;
        for (int d = 0; d < ND; d++) begin
            best = ram[0];
            for (int i = 1; i < DEPTH; i++) if (beats(d, ram[i], best)) best = ram[i];
            fi = -1;
            for (int i = DEPTH - 1; i >= 0; i--) if (ram[i] == best) fi = i;
            pend_data[d] = best;
            pend_addr[d] = AW'(fi);
        end
        pend_flag = 1'b1;
        for (int i = 1; i < DEPTH; i++) if (ram[i] != ram[0]) pend_flag = 1'b0;
    endfunction

    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_p = 0; m_rdy_prev = 1; m_ext_valid = 0; m_flag = 0;
            for (int d = 0; d < ND; d++) begin m_ext_data[d] = '0; m_ext_addr[d] = '0; end
        end else begin
            m_start = readyb && !m_rdy_prev;
            m_rdy_prev = readyb;
            if (m_active) begin
                if (abort && m_p <= DEPTH + RDL) begin
                    m_active = 0; m_p = 0;
                end else begin
                    m_p++;
                    if (m_p == DEPTH + RDL + 1) begin
                        for (int d = 0; d < ND; d++) begin
                            m_ext_data[d] = pend_data[d]; m_ext_addr[d] = pend_addr[d];
                        end
                        m_ext_valid = 1; m_flag = pend_flag;
                    end else if (m_p > DEPTH + RDL + 1) begin
                        m_active = 0; m_p = 0;
                    end
                end
            end else if (m_start && !abort) begin
                m_active = 1; m_p = 1; m_ext_valid = 0; m_flag = 0;
                for (int d = 0; d < ND; d++) begin m_ext_data[d] = '0; m_ext_addr[d] = '0; end
                compute_pending();
            end
        end
    end

    function automatic logic [25:0] exp_vec(int d);
        logic [AW-1:0] ea;
        logic eb, ef;
        ea = (m_active && m_p <= DEPTH) ? AW'(m_p - 1) : '0;
        eb = m_active && (m_p <= DEPTH + RDL);
        ef = m_active && (m_p == DEPTH + RDL + 1);
        return {ea, eb, ef, m_ext_data[d], m_ext_addr[d], m_ext_valid, m_flag};
    endfunction

    function automatic logic [25:0] act_vec(int d);
        return {addr_w[d], busy[d], finishb[d], ext_data_w[d], ext_addr_w[d], ext_valid[d], flag[d]};
    endfunction

    always @(negedge clk_in) begin
        if (cmp_en) begin
            for (int d = 0; d < ND; d++) begin
                checks++;
                if (act_vec(d) !== exp_vec(d)) begin
                    errors++;
                    $display("FAIL cycle_cmp dut%0d t=%0t got {addr,busy,fin,data,eaddr,valid,flag}=%h expected %h",
                             d, $time, act_vec(d), exp_vec(d));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    // Starts a sweep from negedge+1 and returns the cycle index (T+n) at which finishb[0] is seen
    task automatic run_sweep(input bit extra_edge, output int n);
        readyb = 1'b1;
        n = 0;
        while (1) begin
            step();
            n++;
            if (n == 1) readyb = 1'b0;
            if (extra_edge && n == 40) readyb = 1'b1;
            if (extra_edge && n == 41) readyb = 1'b0;
            if (finishb[0]) break;
            if (n >= 300) begin
                checks++; errors++;
                $display("FAIL sweep_timeout got no finishb expected one by T+%0d", DEPTH + RDL + 1);
                break;
            end
        end
    endtask

    int n, cnt;

    initial begin
        rst_n = 1'b0; readyb = 1'b1; abort = 1'b0;
        for (int i = 0; i < DEPTH; i++) ram[i] = '0;
        repeat (3) step();
        check("rst_addr", addr_w[0], 0);
        check("rst_busy", busy[0], 0);
        check("rst_ext_valid", ext_valid[0], 0);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        repeat (5) step();
        check("rdy_high_at_release_no_sweep", busy[0], 0);
        readyb = 1'b0;
        repeat (3) step();

        // Ramp: max is the last address
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i);
        run_sweep(1'b0, n);
        check("ramp_finish_cycle", n, 131);
        check("ramp_ext_data", ext_data_w[0], 127);
        check("ramp_ext_addr", ext_addr_w[0], 127);
        check("ramp_no_ext", flag[0], 0);
        check("ramp_min_ext_addr", ext_addr_w[2], 0);
        step();
        check("ramp_finish_one_cycle", finishb[0], 0);
        check("ramp_valid_holds", ext_valid[0], 1);
        repeat (4) step();

        // All equal
        for (int i = 0; i < DEPTH; i++) ram[i] = 8'h55;
        run_sweep(1'b0, n);
        check("flat_ext_data", ext_data_w[0], 'h55);
        check("flat_ext_addr", ext_addr_w[0], 0);
        check("flat_no_ext", flag[0], 1);
        repeat (4) step();

        // Tie: first occurrence wins
        for (int i = 0; i < DEPTH; i++) ram[i] = 8'h10;
        ram[10] = 8'h80; ram[90] = 8'h80;
        run_sweep(1'b0, n);
        check("tie_ext_data", ext_data_w[0], 'h80);
        check("tie_ext_addr", ext_addr_w[0], 10);
        repeat (4) step();

        // Signed vs unsigned min
        for (int i = 0; i < DEPTH; i++) ram[i] = 8'h05;
        ram[33] = 8'hF0;
        run_sweep(1'b0, n);
        check("smin_ext_data", ext_data_w[1], 'hF0);
        check("smin_ext_addr", ext_addr_w[1], 33);
        check("umin_ext_data", ext_data_w[2], 'h05);
        check("umin_ext_addr", ext_addr_w[2], 0);
        repeat (4) step();

        // Second edge while busy is dropped, not queued
        run_sweep(1'b1, n);
        check("ignored_edge_finish_cycle", n, 131);
        cnt = 0;
        repeat (150) begin step(); if (finishb[0]) cnt++; end
        check("ignored_edge_no_second_finish", cnt, 0);

        // Abort mid-sweep
        readyb = 1'b1;
        n = 0;
        repeat (51) begin
            step(); n++;
            if (n == 1) readyb = 1'b0;
            if (n == 50) abort = 1'b1;
        end
        abort = 1'b0;
        check("abort_busy_low", busy[0], 0);
        check("abort_ext_valid", ext_valid[0], 0);
        cnt = 0;
        repeat (150) begin step(); if (finishb[0]) cnt++; end
        check("abort_no_finish", cnt, 0);

        // Abort and start in the same cycle: abort wins
        readyb = 1'b1; abort = 1'b1;
        step();
        readyb = 1'b0; abort = 1'b0;
        step();
        check("abort_with_start_no_sweep", busy[0], 0);
        repeat (3) step();

        // Asynchronous reset mid-sweep
        readyb = 1'b1;
        repeat (60) begin step(); readyb = 1'b0; end
        check("pre_reset_busy", busy[0], 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_addr", addr_w[0], 0);
        check("async_rst_busy", busy[0], 0);
        check("async_rst_finishb", finishb[0], 0);
        check("async_rst_ext_valid", ext_valid[0], 0);
        check("async_rst_ext_data", ext_data_w[0], 0);
        check("async_rst_no_ext", flag[0], 0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (5) step();
        check("post_reset_idle", busy[0], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
